otp_serial_ctrl: RTL and testbench
==================================

Name: otp_serial_ctrl

Overview:
Bit-serial one-time-pad cipher controller. Accepts a MSG_BITS message and a KEY_BITS key through a valid/ready handshake, then feeds one message bit and one key bit per clock through a 1-bit XOR stage, MSB first. The key repeats every KEY_BITS bits. The controller assembles the result word and presents it on an output valid/ready handshake. Encryption and decryption are the same operation, so one instance serves both paths of the OTP demo.

Parameters:
MSG_BITS, 64, message/result width; must be a nonzero multiple of KEY_BITS.
KEY_BITS, 32, key width; key bit used for message bit i is key[i % KEY_BITS].

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  msg/key valid.
in_ready  out  1  controller can accept a job.
in_msg  in  MSG_BITS  plaintext or ciphertext.
in_key  in  KEY_BITS  OTP key.
abort  in  1  synchronous cancel of the current job.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  MSG_BITS  XOR result.
busy  out  1  high in RUN.
ser_a  out  1  message bit currently at the XOR input (debug tap).
ser_b  out  1  key bit currently at the XOR input.
ser_out  out  1  XOR output bit.
bit_idx  out  $clog2(MSG_BITS)  index of the bit being processed.

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1 after reset is released. out_valid=0, busy=0, out_data=0, ser_a/ser_b/ser_out=0, bit_idx=MSG_BITS-1.
- FSM states are IDLE, RUN and DONE.
- IDLE: in_ready=1. On in_valid the controller latches in_msg and in_key into internal registers, sets bit_idx=MSG_BITS-1 and moves to RUN. in_msg and in_key are not sampled again for the rest of the job.
- RUN: in_ready=0, busy=1.
  - Each cycle: ser_a=msg_r[bit_idx], ser_b=key_r[bit_idx % KEY_BITS], ser_out=ser_a^ser_b (combinational through the XOR sub-module).
  - At the clock edge, result_r[bit_idx] is set to ser_out and bit_idx decrements.
  - When bit_idx==0 the edge writes bit 0 and moves to DONE. bit_idx does not wrap below 0; it reloads to MSG_BITS-1.
  - Key index wraps to KEY_BITS-1 after reaching 0 on each KEY_BITS boundary.
- DONE: out_valid=1, out_data=result_r, held stable until out_ready=1. The edge with out_valid&&out_ready returns to IDLE with out_valid=0. out_data keeps its value until the next job writes it.
- Latency: the acceptance edge is edge 0. RUN spans exactly MSG_BITS cycles. out_valid is high after edge MSG_BITS. Minimum throughput is one job per MSG_BITS+2 cycles.
- in_ready is 0 in RUN and DONE. A pending in_valid waits and is not dropped.
- abort:
  - In RUN: next edge goes to IDLE, result_r is cleared to 0, out_valid stays 0.
  - In DONE: output is discarded, go to IDLE.
  - In IDLE: ignored.
  - abort takes priority over out_ready.
- Reset asserted mid-job discards all state immediately.
- Outside RUN, ser_a, ser_b and ser_out are driven 0.

Optional Feature:
Macro OTP_KEY_REUSE_DETECT_EN. When defined:
- Adds output key_reuse (1 bit) and a register last_key (KEY_BITS, reset 0, plus a reset-cleared last_key_vld flag).
- On each accepted job, if last_key_vld and in_key==last_key, key_reuse is set and stays set through that job's DONE. It clears on the next acceptance that has a different key.
- last_key is updated on every acceptance.
- Without the macro, the port and the registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Package otp_pkg: state enum typedef otp_state_t {IDLE, RUN, DONE}; default constants OTP_MSG_BITS=64 and OTP_KEY_BITS=32.
- One sub-module otp_xor_bit (a, b -> out), instantiated once as the serial XOR stage. It is kept separate so it can be swapped or probed.

Test Plan:
1. Encrypt: msg=0x7472616261_6C686F ("trabalho"), key=0x63696E63. Expected: out_data=0x171B0F010205060C, out_valid rises 64 cycles after acceptance.
2. Decrypt: msg=0x171B0F010205060C, same key. Expected: out_data=0x7472616261_6C686F. Serial ser_out stream equals the plaintext MSB-first.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1. Expected: out_data stable, in_ready=0, and the second job is accepted on the cycle after the out handshake.
4. Abort at bit_idx=40. Expected: IDLE next cycle, out_valid never asserts, and a following job produces the correct result.
5. Reset pulse mid-RUN. Expected: all outputs return to reset values asynchronously, in_ready=1 after release.
6. (OTP_KEY_REUSE_DETECT_EN) Two jobs with key 0x63696E63, then one with key 0x00000001. Expected: key_reuse = 0, 1, 0 respectively.

Source files
------------

// File: rtl/otp_pkg.sv
// Shared definitions for the bit-serial one-time-pad controller.
package otp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } otp_state_t;

  localparam int OTP_MSG_BITS = 64;
  localparam int OTP_KEY_BITS = 32;

endpackage

// File: rtl/otp_xor_bit.sv
// Single-bit XOR stage of the serial cipher path; kept as its own module so
// it can be swapped for a different combiner or probed on its own.
module otp_xor_bit (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = a ^ b;

endmodule

// File: rtl/otp_serial_ctrl.sv
// Bit-serial one-time-pad controller. A message/key pair is latched on the
// input handshake, then one message bit and one key bit per clock (MSB first,
// key repeating every KEY_BITS bits) pass through a 1-bit XOR stage and the
// result word is assembled and offered on the output handshake.
// Optional feature macro: OTP_KEY_REUSE_DETECT_EN adds the key_reuse output,
// flagging a job whose key equals the key of the previously accepted job.
module otp_serial_ctrl
  import otp_pkg::*;
#(
  parameter int MSG_BITS = OTP_MSG_BITS,
  parameter int KEY_BITS = OTP_KEY_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MSG_BITS-1:0]         in_msg,
  input  logic [KEY_BITS-1:0]         in_key,
  input  logic                        abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MSG_BITS-1:0]         out_data,
  output logic                        busy,
  output logic                        ser_a,
  output logic                        ser_b,
  output logic                        ser_out,
`ifdef OTP_KEY_REUSE_DETECT_EN
  output logic                        key_reuse,
`endif
  output logic [$clog2(MSG_BITS)-1:0] bit_idx
);

  localparam int IDX_W  = $clog2(MSG_BITS);
  localparam int KIDX_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(MSG_BITS - 1);
  localparam logic [KIDX_W-1:0] KIDX_MAX = KIDX_W'(KEY_BITS - 1);

  otp_state_t state, state_next;

  logic [MSG_BITS-1:0] msg_r;
  logic [KEY_BITS-1:0] key_r;
  logic [MSG_BITS-1:0] result_r;
  logic [KIDX_W-1:0]   key_idx;
  logic                accept;

  assign accept   = in_ready && in_valid;
  assign out_data = result_r;

  // Serial operands are only presented while a job is running, zero otherwise.
  assign ser_a = busy ? msg_r[bit_idx] : 1'b0;
  assign ser_b = busy ? key_r[key_idx] : 1'b0;

  otp_xor_bit u_xor (
    .a   (ser_a),
    .b   (ser_b),
    .out (ser_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake/status decode; abort wins over out_ready.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort)                state_next = IDLE;
        else if (bit_idx == '0)   state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit/key index counters and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_r    <= '0;
      key_r    <= '0;
      result_r <= '0;
      bit_idx  <= IDX_MAX;
      key_idx  <= KIDX_MAX;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            msg_r   <= in_msg;
            key_r   <= in_key;
            bit_idx <= IDX_MAX;
            key_idx <= KIDX_MAX;
          end
        end
        RUN: begin
          if (abort) begin
            result_r <= '0;
            bit_idx  <= IDX_MAX;
            key_idx  <= KIDX_MAX;
          end else begin
            result_r[bit_idx] <= ser_out;
            bit_idx <= (bit_idx == '0) ? IDX_MAX : bit_idx - 1'b1;
            key_idx <= (key_idx == '0) ? KIDX_MAX : key_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OTP_KEY_REUSE_DETECT_EN
  logic [KEY_BITS-1:0] last_key;
  logic                last_key_vld;

  // Compare each accepted key with the previous one and remember it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_key     <= '0;
      last_key_vld <= 1'b0;
      key_reuse    <= 1'b0;
    end else if (accept) begin
      key_reuse    <= last_key_vld && (in_key == last_key);
      last_key     <= in_key;
      last_key_vld <= 1'b1;
    end
  end
`else
  // No key history is kept in the default build.
`endif

endmodule

// File: tb/tb_otp_serial_ctrl.sv
// Self-checking bench for otp_serial_ctrl: a word-level reference model runs
// alongside the DUT and every output is compared on each falling edge, with
// directed scenarios (known-answer encrypt/decrypt, backpressure, abort,
// mid-job reset, key reuse when OTP_KEY_REUSE_DETECT_EN is defined) followed
// by randomized jobs.
module tb_otp_serial_ctrl;

  localparam int MSG_BITS = 64;
  localparam int KEY_BITS = 32;
  localparam int IDX_W    = $clog2(MSG_BITS);
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                abort = 1'b0;
  logic                out_ready = 1'b0;
  logic [MSG_BITS-1:0] in_msg = '0;
  logic [KEY_BITS-1:0] in_key = '0;
  logic                in_ready, out_valid, busy, ser_a, ser_b, ser_out;
  logic [MSG_BITS-1:0] out_data;
  logic [IDX_W-1:0]    bit_idx;
`ifdef OTP_KEY_REUSE_DETECT_EN
  logic                key_reuse;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  bit chk_en   = 1'b0;
  logic [MSG_BITS-1:0] ser_stream = '0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  otp_serial_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .in_key    (in_key),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_out   (ser_out),
`ifdef OTP_KEY_REUSE_DETECT_EN
    .key_reuse (key_reuse),
`endif
    .bit_idx   (bit_idx)
  );

  // Whole-word cipher: message XOR the key replicated across the word.
  function automatic logic [MSG_BITS-1:0] otp_word(input logic [MSG_BITS-1:0] msg,
                                                   input logic [KEY_BITS-1:0] key);
    return msg ^ {(MSG_BITS/KEY_BITS){key}};
  endfunction

  task automatic checkOutput(input string name, input logic [MSG_BITS-1:0] act,
                             input logic [MSG_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: job phase, bits completed, captured operands.
  int                  m_st = M_IDLE;
  int                  m_cnt = 0;
  logic [MSG_BITS-1:0] m_msg = '0;
  logic [KEY_BITS-1:0] m_key = '0;
  logic [MSG_BITS-1:0] m_result = '0;
  logic                m_reuse = 1'b0;
  logic                m_last_vld = 1'b0;
  logic [KEY_BITS-1:0] m_last_key = '0;

  // Reference model advanced on every rising edge, cleared asynchronously.
  always @(posedge clk or negedge rst_n) begin : model_blk
    int idx;
    if (!rst_n) begin
      m_st = M_IDLE; m_cnt = 0; m_msg = '0; m_key = '0; m_result = '0;
      m_reuse = 1'b0; m_last_vld = 1'b0; m_last_key = '0;
    end else begin
      case (m_st)
        M_IDLE: if (in_valid) begin
          m_msg = in_msg; m_key = in_key; m_cnt = 0; m_st = M_RUN;
          m_reuse = m_last_vld && (in_key == m_last_key);
          m_last_key = in_key; m_last_vld = 1'b1;
        end
        M_RUN: if (abort) begin
          m_result = '0; m_st = M_IDLE;
        end else begin
          idx = MSG_BITS - 1 - m_cnt;
          m_result[idx] = m_msg[idx] ^ m_key[idx % KEY_BITS];
          m_cnt++;
          if (m_cnt == MSG_BITS) m_st = M_DONE;
        end
        default: if (abort || out_ready) m_st = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare_blk
    int idx;
    logic run;
    if (rst_n && chk_en) begin
      run = (m_st == M_RUN);
      idx = run ? MSG_BITS - 1 - m_cnt : MSG_BITS - 1;
      checkOutput("in_ready",  in_ready,  m_st == M_IDLE);
      checkOutput("busy",      busy,      run);
      checkOutput("out_valid", out_valid, m_st == M_DONE);
      checkOutput("out_data",  out_data,  m_result);
      checkOutput("bit_idx",   bit_idx,   idx);
      checkOutput("ser_a",     ser_a,     run ? m_msg[idx] : 1'b0);
      checkOutput("ser_b",     ser_b,     run ? m_key[idx % KEY_BITS] : 1'b0);
      checkOutput("ser_out",   ser_out,   run ? m_msg[idx] ^ m_key[idx % KEY_BITS] : 1'b0);
`ifdef OTP_KEY_REUSE_DETECT_EN
      checkOutput("key_reuse", key_reuse, m_reuse);
`endif
      if (busy) ser_stream = {ser_stream[MSG_BITS-2:0], ser_out};
    end
  end

  // Present a job and return just after the edge that accepts it.
  task automatic applyStimulus(input logic [MSG_BITS-1:0] msg, input logic [KEY_BITS-1:0] key);
    int waited;
    @(posedge clk); #2;
    in_msg = msg; in_key = key; in_valid = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!in_ready && waited < 300);
    if (!in_ready) checkOutput("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    acc_edge = edge_cnt;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin @(negedge clk); cycles++; end while (!out_valid && cycles < 300);
    if (!out_valid) checkOutput("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
  endtask

  localparam logic [MSG_BITS-1:0] PLAIN  = 64'h74726162616C686F;
  localparam logic [MSG_BITS-1:0] CIPHER = 64'h171B0F010205060C;
  localparam logic [KEY_BITS-1:0] KEY0   = 32'h63696E63;

  initial begin
    int cyc;
    int seen;
    logic [MSG_BITS-1:0] msg_a, msg_b, rmsg;
    logic [KEY_BITS-1:0] key_b, rkey, prev_key;

    // Power-on reset and reset-value check.
    #22 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_bit_idx", bit_idx, MSG_BITS - 1);
    checkOutput("model_kat", otp_word(PLAIN, KEY0), CIPHER);

    // Encrypt known answer and latency.
    $display("[TB] encrypt");
    applyStimulus(PLAIN, KEY0);
    wait_done(cyc);
    checkOutput("enc_latency", edge_cnt - acc_edge, MSG_BITS);
    checkOutput("enc_data", out_data, CIPHER);
    drain();

    // Decrypt known answer and serial stream.
    $display("[TB] decrypt");
    applyStimulus(CIPHER, KEY0);
    wait_done(cyc);
    checkOutput("dec_data", out_data, PLAIN);
    checkOutput("dec_stream", ser_stream, PLAIN);
    drain();

    // Backpressure with a second job waiting.
    $display("[TB] backpressure");
    msg_a = {$urandom, $urandom};
    msg_b = {$urandom, $urandom};
    key_b = $urandom;
    applyStimulus(msg_a, KEY0);
    in_msg = msg_b; in_key = key_b; in_valid = 1'b1;
    wait_done(cyc);
    repeat (10) begin
      @(negedge clk);
      checkOutput("bp_data", out_data, otp_word(msg_a, KEY0));
      checkOutput("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_gap_ready", in_ready, 1'b1);
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_second_busy", busy, 1'b1);
    wait_done(cyc);
    checkOutput("bp_second_data", out_data, otp_word(msg_b, key_b));
    drain();

    // Abort in the middle of a job.
    $display("[TB] abort");
    applyStimulus(msg_b, KEY0);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bit_idx != 40 && cyc < 100);
    checkOutput("abort_reach40", bit_idx, 40);
    abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", in_ready, 1'b1);
    checkOutput("abort_cleared", out_data, '0);
    seen = 0;
    repeat (70) begin @(negedge clk); if (out_valid) seen = 1; end
    checkOutput("abort_no_valid", seen, 0);
    applyStimulus(msg_a, key_b);
    wait_done(cyc);
    checkOutput("post_abort_data", out_data, otp_word(msg_a, key_b));
    drain();

    // Reset pulse mid-job.
    $display("[TB] reset mid-run");
    applyStimulus(msg_a, KEY0);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mrst_busy", busy, 1'b0);
    checkOutput("mrst_out_valid", out_valid, 1'b0);
    checkOutput("mrst_out_data", out_data, '0);
    checkOutput("mrst_bit_idx", bit_idx, MSG_BITS - 1);
    checkOutput("mrst_ser", {ser_a, ser_b, ser_out}, 3'b000);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mrst_in_ready", in_ready, 1'b1);

`ifdef OTP_KEY_REUSE_DETECT_EN
    // Key reuse flag across three jobs.
    $display("[TB] key reuse");
    applyStimulus(PLAIN, KEY0);
    wait_done(cyc);
    checkOutput("reuse_job1", key_reuse, 1'b0);
    drain();
    applyStimulus(CIPHER, KEY0);
    wait_done(cyc);
    checkOutput("reuse_job2", key_reuse, 1'b1);
    drain();
    applyStimulus(PLAIN, 32'h00000001);
    wait_done(cyc);
    checkOutput("reuse_job3", key_reuse, 1'b0);
    drain();
`endif

    // Randomized jobs with occasional aborts and output stalls.
    $display("[TB] random jobs");
    prev_key = KEY0;
    for (int j = 0; j < 16; j++) begin
      rmsg = {$urandom, $urandom};
      rkey = ($urandom_range(0, 3) == 0) ? prev_key : KEY_BITS'($urandom);
      prev_key = rkey;
      applyStimulus(rmsg, rkey);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 72)) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
      end else begin
        wait_done(cyc);
        checkOutput("rand_data", out_data, otp_word(rmsg, rkey));
        repeat ($urandom_range(0, 5)) @(posedge clk);
        drain();
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
